// File: rtl/grid_env.sv
`default_nettype none
// ============================================================================
// Module   : grid_env
// Purpose  : Grid-world environment stage for the DQN datapath. It applies one
//            agent action per CU step, exposes the next state st1 to the CU,
//            and tracks the reward and the per-episode return.
// Ports    : clk, rst (async, active low)
//            controller[3:0], step[3:0]      CU phase / step counters
//            action[1:0], action_valid       0=up 1=right 2=down 3=left
//            st[3:0], st1[3:0]               current / next state
//            reward[7:0], reward_valid       signed reward of last move, pulse
//            done                            st1==GOAL_STATE pending commit
//            ret[11:0], ret_last[11:0]       running / last-episode return
//            ret_valid                       pulse, ret_last updated
// Config   : GRID_ENV_HOLE_EN adds a hole cell (HOLE_STATE, R_HOLE) that
//            teleports the agent back to START_STATE.
// Revision : 1.0 - initial release
// ============================================================================
module grid_env #(
  parameter int GRID_W       = 3,
  parameter int GRID_H       = 3,
  parameter int START_STATE  = 1,
  parameter int GOAL_STATE   = 9,
  parameter int ACT_PHASE    = 2,
  parameter int COMMIT_PHASE = 9,
  parameter int MAX_STEP     = 15,
  parameter int R_STEP       = -1,
  parameter int R_WALL       = -2,
  parameter int R_GOAL       = 10
`ifdef GRID_ENV_HOLE_EN
  ,
  parameter int HOLE_STATE   = 5,
  parameter int R_HOLE       = -10
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  controller,
  input  logic [3:0]  step,
  input  logic [1:0]  action,
  input  logic        action_valid,
  output logic [3:0]  st,
  output logic [3:0]  st1,
  output logic [7:0]  reward,
  output logic        reward_valid,
  output logic        done,
  output logic [11:0] ret,
  output logic [11:0] ret_last,
  output logic        ret_valid
);

  localparam logic [3:0] c_W      = 4'(GRID_W);
  localparam logic [3:0] c_H      = 4'(GRID_H);
  localparam logic [3:0] c_START  = 4'(START_STATE);
  localparam logic [3:0] c_GOAL   = 4'(GOAL_STATE);
  localparam logic [3:0] c_ACT    = 4'(ACT_PHASE);
  localparam logic [3:0] c_COMMIT = 4'(COMMIT_PHASE);
  localparam logic [3:0] c_MAX    = 4'(MAX_STEP);
  localparam logic [7:0] c_R_STEP = 8'(R_STEP);
  localparam logic [7:0] c_R_WALL = 8'(R_WALL);
  localparam logic [7:0] c_R_GOAL = 8'(R_GOAL);
`ifdef GRID_ENV_HOLE_EN
  localparam logic [3:0] c_HOLE   = 4'(HOLE_STATE);
  localparam logic [7:0] c_R_HOLE = 8'(R_HOLE);
`endif

  logic [3:0]  r_st, r_st1;
  logic [7:0]  r_reward;
  logic        r_reward_valid, r_done;
  logic [11:0] r_ret, r_ret_last;
  logic        r_ret_valid;

  logic        w_act, w_commit, w_end;
  logic [3:0]  w_idx, w_row, w_col;
  logic        w_blocked;
  logic [3:0]  w_target;
  logic [3:0]  w_st1_next;
  logic [7:0]  w_rew;
  logic        w_done_next;
  logic [12:0] w_sum;
  logic [11:0] w_ret_sat;

  assign w_act    = (controller == c_ACT) && action_valid;
  assign w_commit = (controller == c_COMMIT);
  // Goal and step limit together still make a single episode end.
  assign w_end    = (r_st1 == c_GOAL) || (step == c_MAX);

  // States are 1-based, row-major.
  assign w_idx = r_st - 4'd1;
  assign w_row = w_idx / c_W;
  assign w_col = w_idx % c_W;

  always_comb begin
    w_blocked = 1'b0;
    w_target  = r_st;
    case (action)
      2'd0: if (w_row == 4'd0)       w_blocked = 1'b1; else w_target = r_st - c_W;
      2'd1: if (w_col == c_W - 4'd1) w_blocked = 1'b1; else w_target = r_st + 4'd1;
      2'd2: if (w_row == c_H - 4'd1) w_blocked = 1'b1; else w_target = r_st + c_W;
      default: if (w_col == 4'd0)    w_blocked = 1'b1; else w_target = r_st - 4'd1;
    endcase
  end

  always_comb begin
    w_st1_next  = w_target;
    w_rew       = c_R_STEP;
    w_done_next = 1'b0;
    if (w_blocked) begin
      w_st1_next = r_st;
      w_rew      = c_R_WALL;
    end else if (w_target == c_GOAL) begin
      w_rew       = c_R_GOAL;
      w_done_next = 1'b1;
    end
`ifdef GRID_ENV_HOLE_EN
    else if (w_target == c_HOLE) begin
      // Falling in the hole restarts the position, not the episode.
      w_st1_next = c_START;
      w_rew      = c_R_HOLE;
    end
`endif
  end

  // 13-bit sum of sign-extended operands, clamped to the 12-bit range.
  assign w_sum = {r_ret[11], r_ret} + {{5{w_rew[7]}}, w_rew};

  always_comb begin
    w_ret_sat = w_sum[11:0];
    if ($signed(w_sum) > 13'sd2047)       w_ret_sat = 12'h7FF;
    else if ($signed(w_sum) < -13'sd2048) w_ret_sat = 12'h800;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st           <= c_START;
      r_st1          <= c_START;
      r_reward       <= 8'd0;
      r_reward_valid <= 1'b0;
      r_done         <= 1'b0;
      r_ret          <= 12'd0;
      r_ret_last     <= 12'd0;
      r_ret_valid    <= 1'b0;
    end else begin
      r_reward_valid <= 1'b0;
      r_ret_valid    <= 1'b0;
      if (w_act) begin
        r_st1          <= w_st1_next;
        r_reward       <= w_rew;
        r_reward_valid <= 1'b1;
        r_done         <= w_done_next;
        r_ret          <= w_ret_sat;
      end else if (w_commit) begin
        if (w_end) begin
          r_st        <= c_START;
          r_st1       <= c_START;
          r_done      <= 1'b0;
          r_ret_last  <= r_ret;
          r_ret       <= 12'd0;
          r_ret_valid <= 1'b1;
        end else begin
          r_st <= r_st1;
        end
      end
    end
  end

  assign st           = r_st;
  assign st1          = r_st1;
  assign reward       = r_reward;
  assign reward_valid = r_reward_valid;
  assign done         = r_done;
  assign ret          = r_ret;
  assign ret_last     = r_ret_last;
  assign ret_valid    = r_ret_valid;

endmodule
`default_nettype wire

// File: tb/tb_grid_env.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_env
// Purpose  : Directed self-checking bench for grid_env (3x3 grid, defaults).
//            Honours GRID_ENV_HOLE_EN for the hole-cell expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_env;

  localparam logic [1:0] c_UP = 2'd0, c_RIGHT = 2'd1, c_DOWN = 2'd2, c_LEFT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  controller;
  logic [3:0]  step;
  logic [1:0]  action;
  logic        action_valid;
  logic [3:0]  st, st1;
  logic [7:0]  reward;
  logic        reward_valid, done;
  logic [11:0] ret, ret_last;
  logic        ret_valid;

  int vectors = 0;
  int miscompares = 0;

  // Values captured by step_run.
  logic [3:0]        st1_act, st1_pre;
  logic signed [7:0] rew_act;
  logic              done_act;
  logic [11:0]       ret_act;
  int                rv_cnt, retv_cnt;
  int                acc_a, acc_b, acc_c;

  grid_env dut (
    .clk(clk), .rst(rst), .controller(controller), .step(step),
    .action(action), .action_valid(action_valid), .st(st), .st1(st1),
    .reward(reward), .reward_valid(reward_valid), .done(done), .ret(ret),
    .ret_last(ret_last), .ret_valid(ret_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic [3:0] s,
                     input logic [1:0] a, input logic v);
    controller = c; step = s; action = a; action_valid = v;
    @(posedge clk); #1;
  endtask

  // One full CU step (phases 1..9); action_valid is held for the whole step
  // so that only its phase-2 sampling may matter.
  task automatic step_run(input logic [3:0] s, input logic [1:0] a, input logic v);
    rv_cnt = 0; retv_cnt = 0;
    for (int ph = 1; ph <= 9; ph++) begin
      cyc(4'(ph), s, a, v);
      if (ph == 2) begin
        st1_act = st1; rew_act = $signed(reward); done_act = done; ret_act = ret;
      end
      if (ph == 8) st1_pre = st1;
      rv_cnt   += int'(reward_valid);
      retv_cnt += int'(ret_valid);
    end
  endtask

  initial begin
    rst = 1'b1; controller = 4'd0; step = 4'd0; action = c_RIGHT; action_valid = 1'b1;

    // ---- reset ---------------------------------------------------------
    #3 rst = 1'b0; #1;
    chk("rst_st", st, 1);          chk("rst_st1", st1, 1);
    chk("rst_reward", $signed(reward), 0);
    chk("rst_rv", reward_valid, 0); chk("rst_done", done, 0);
    chk("rst_ret", $signed(ret), 0); chk("rst_ret_last", $signed(ret_last), 0);
    chk("rst_retv", ret_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(4'd0, 4'd0, c_RIGHT, 1'b1);
    cyc(4'd0, 4'd0, c_RIGHT, 1'b1);
    chk("idle_st1", st1, 1); chk("idle_rv", reward_valid, 0);
    chk("idle_reward", $signed(reward), 0);

    // ---- episode A: walls at 1(up) and 3(right), then goal -------------
    step_run(4'd1, c_UP, 1'b1);
    chk("A1_st1", st1_act, 1); chk("A1_rew", rew_act, -2); chk("A1_rvcnt", rv_cnt, 1);
    chk("A1_ret", $signed(ret), -2);
    step_run(4'd2, c_RIGHT, 1'b1);
    chk("A2_st1", st1_act, 2); chk("A2_rew", rew_act, -1); chk("A2_rvcnt", rv_cnt, 1);
    chk("A2_st", st, 2); chk("A2_ret", $signed(ret), -3);
    step_run(4'd3, c_RIGHT, 1'b1);
    chk("A3_st", st, 3);
    step_run(4'd4, c_RIGHT, 1'b1);
    chk("A4_st1", st1_act, 3); chk("A4_rew", rew_act, -2); chk("A4_ret", $signed(ret), -6);
    step_run(4'd5, c_DOWN, 1'b1);
    chk("A5_st", st, 6);
    step_run(4'd6, c_DOWN, 1'b1);
    chk("A6_rew", rew_act, 10); chk("A6_done", done_act, 1); chk("A6_st1pre", st1_pre, 9);
    chk("A6_st", st, 1); chk("A6_st1", st1, 1); chk("A6_donepost", done, 0);
    chk("A6_ret", $signed(ret), 0); chk("A6_ret_last", $signed(ret_last), 3);
    chk("A6_retv", retv_cnt, 1);

    // ---- episode B: clean path 1-2-3-6-9 -------------------------------
    step_run(4'd1, c_RIGHT, 1'b1);
    step_run(4'd2, c_RIGHT, 1'b1);
    step_run(4'd3, c_DOWN, 1'b1);
    chk("B3_retv", retv_cnt, 0);
    step_run(4'd4, c_DOWN, 1'b1);
    chk("B4_rew", rew_act, 10); chk("B4_retact", $signed(ret_act), 7);
    chk("B4_ret_last", $signed(ret_last), 7); chk("B4_retv", retv_cnt, 1);
    chk("B4_st", st, 1);

    // ---- asynchronous reset in the middle of a step --------------------
    cyc(4'd1, 4'd1, c_RIGHT, 1'b1);
    cyc(4'd2, 4'd1, c_RIGHT, 1'b1);
    chk("mid_st1_moved", st1, 2);
    cyc(4'd3, 4'd1, c_RIGHT, 1'b1);
    #2 rst = 1'b0; #1;
    chk("mid_st", st, 1); chk("mid_st1", st1, 1);
    chk("mid_reward", $signed(reward), 0); chk("mid_ret", $signed(ret), 0);
    chk("mid_ret_last", $signed(ret_last), 0); chk("mid_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ---- episode C: move next to the hole cell, then idle to step 15 ---
    step_run(4'd1, c_RIGHT, 1'b1);
    step_run(4'd2, c_DOWN, 1'b1);
`ifdef GRID_ENV_HOLE_EN
    chk("C2_st1", st1_act, 1); chk("C2_rew", rew_act, -10); chk("C2_done", done_act, 0);
    chk("C2_st", st, 1);
`else
    chk("C2_st1", st1_act, 5); chk("C2_rew", rew_act, -1); chk("C2_done", done_act, 0);
    chk("C2_st", st, 5);
`endif
    acc_a = 0;
    for (int s = 3; s <= 15; s++) begin
      step_run(4'(s), c_LEFT, 1'b0);
      acc_a += rv_cnt;
    end
    chk("C_idle_rv", acc_a, 0); chk("C_retv", retv_cnt, 1);
`ifdef GRID_ENV_HOLE_EN
    chk("C_ret_last", $signed(ret_last), -11); chk("C_reward_kept", $signed(reward), -10);
`else
    chk("C_ret_last", $signed(ret_last), -2);  chk("C_reward_kept", $signed(reward), -1);
`endif
    chk("C_st", st, 1); chk("C_ret", $signed(ret), 0);

    // ---- episode D: 15 steps with no valid action ----------------------
    acc_a = 0; acc_b = 0; acc_c = 0;
    for (int s = 1; s <= 15; s++) begin
      step_run(4'(s), c_RIGHT, 1'b0);
      acc_a += int'(st1_act != 4'd1);
      acc_b += rv_cnt;
      acc_c += retv_cnt;
    end
    chk("D_st1_moves", acc_a, 0); chk("D_rv", acc_b, 0); chk("D_retv", acc_c, 1);
    chk("D_ret_last", $signed(ret_last), 0); chk("D_st", st, 1);

    // ---- saturation: repeated wall hits drive ret to -2048 -------------
    for (int i = 0; i < 1030; i++) step_run(4'd0, c_UP, 1'b1);
    chk("S_ret", $signed(ret), -2048); chk("S_reward", $signed(reward), -2);
    chk("S_ret_last", $signed(ret_last), 0);
    step_run(4'd15, c_UP, 1'b0);
    chk("S_ret_last_end", $signed(ret_last), -2048); chk("S_retv", retv_cnt, 1);
    chk("S_ret_end", $signed(ret), 0);

    // ---- goal reached exactly on the step limit: a single end ----------
    acc_a = 0;
    step_run(4'd12, c_RIGHT, 1'b1); acc_a += retv_cnt;
    step_run(4'd13, c_RIGHT, 1'b1); acc_a += retv_cnt;
    step_run(4'd14, c_DOWN, 1'b1);  acc_a += retv_cnt;
    chk("G_early_retv", acc_a, 0);
    step_run(4'd15, c_DOWN, 1'b1);
    chk("G_retv", retv_cnt, 1); chk("G_ret_last", $signed(ret_last), 7);
    chk("G_st", st, 1); chk("G_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
